// File: rtl/servo_pose_store.sv
// rtl/servo_pose_store.sv - pose memory and byte-command sequencer for the servo arm
//
// Stores NUM_CH servo bytes per pose in DEPTH slots. Commands arrive as bytes:
//   A0 addr d0..d(NUM_CH-1)  save pose
//   B0 addr                  send one pose
//   C0 addr count            play count poses from addr, GAP_CYCLES between frames
// btn_play in IDLE behaves like C0 00 01.
// Optional feature macro: POSE_ACK_EN (save ack 0x55 / 0xEE, play-done 0xAA).
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rx_dv, rx_byte        received byte strobe and data
//   btn_play              debounced single-cycle play request
//   tx_active             UART transmitter busy
//   tx_dv, tx_byte        transmit request strobe and byte (byte held until next strobe)
//   save_pulse            one cycle per committed pose write
//   busy                  FSM not in IDLE
//   playing               read/play byte output in progress, gaps included
//   err_pulse             one cycle per out-of-range address
module servo_pose_store #(
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 256,
  parameter int GAP_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_dv,
  input  logic [7:0] rx_byte,
  input  logic       btn_play,
  input  logic       tx_active,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  output logic       save_pulse,
  output logic       busy,
  output logic       playing,
  output logic       err_pulse
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(NUM_CH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [8:0]    DEPTH9    = 9'(DEPTH);
  localparam logic [7:0]    LAST_ADDR = 8'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(NUM_CH - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_GET_ADDR, ST_GET_DATA, ST_GET_COUNT, ST_FETCH,
    ST_SEND, ST_WAIT_ACT, ST_WAIT_DONE, ST_GAP, ST_NAK
  } state_t;

  typedef enum logic [1:0] {CMD_SAVE, CMD_READ, CMD_PLAY} cmd_t;

  state_t              state;
  cmd_t                cmd;
  logic [7:0]          pose_addr;
  logic [CW-1:0]       ch;
  logic [7:0]          frames_left;
  logic [GW-1:0]       gap_cnt;
  logic [NUM_CH*8-1:0] shadow;
  logic                commit;      // shadow holds a complete pose, write it this cycle
  logic                ack_phase;   // current SEND carries a constant byte, not pose data
  logic                tx_from_mem;
  logic [7:0]          tx_const;
  logic [7:0]          rd_byte;
  logic                addr_oor;
  logic                rx_oor;
  logic                mem_we;

  logic [NUM_CH*8-1:0] mem [DEPTH];

  assign addr_oor = ({1'b0, pose_addr} >= DEPTH9);
  assign rx_oor   = ({1'b0, rx_byte} >= DEPTH9);
  assign mem_we   = (state == ST_GET_DATA) && commit && !addr_oor;

  // tx_byte is a select between two registers; both only change on the edge
  // that raises tx_dv, so the byte is stable between strobes.
  assign tx_byte = tx_from_mem ? rd_byte : tx_const;

  // No reset on the memory or its read register so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[pose_addr[AW-1:0]] <= shadow;
    if (state == ST_FETCH)
      rd_byte <= mem[pose_addr[AW-1:0]][ch*8 +: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cmd         <= CMD_SAVE;
      pose_addr   <= '0;
      ch          <= '0;
      frames_left <= '0;
      gap_cnt     <= '0;
      shadow      <= '0;
      commit      <= 1'b0;
      ack_phase   <= 1'b0;
      tx_from_mem <= 1'b0;
      tx_const    <= 8'h00;
      tx_dv       <= 1'b0;
      save_pulse  <= 1'b0;
      err_pulse   <= 1'b0;
      busy        <= 1'b0;
      playing     <= 1'b0;
    end else begin
      tx_dv      <= 1'b0;
      save_pulse <= 1'b0;
      err_pulse  <= 1'b0;

      case (state)
        ST_IDLE: begin
          // A received byte always wins over the button, even if it is unknown.
          if (rx_dv) begin
            if (rx_byte == 8'hA0 || rx_byte == 8'hB0 || rx_byte == 8'hC0) begin
              cmd   <= (rx_byte == 8'hA0) ? CMD_SAVE :
                       (rx_byte == 8'hB0) ? CMD_READ : CMD_PLAY;
              busy  <= 1'b1;
              state <= ST_GET_ADDR;
            end
          end else if (btn_play) begin
            cmd         <= CMD_PLAY;
            pose_addr   <= 8'h00;
            frames_left <= 8'd1;
            ch          <= '0;
            busy        <= 1'b1;
            playing     <= 1'b1;
            state       <= ST_FETCH;
          end
        end

        ST_GET_ADDR: begin
          if (rx_dv) begin
            pose_addr <= rx_byte;
            ch        <= '0;
            case (cmd)
              CMD_SAVE: state <= ST_GET_DATA;
              CMD_READ: begin
                frames_left <= 8'd1;
                if (rx_oor) begin
                  state <= ST_NAK;
                end else begin
                  playing <= 1'b1;
                  state   <= ST_FETCH;
                end
              end
              default: state <= ST_GET_COUNT;
            endcase
          end
        end

        ST_GET_COUNT: begin
          if (rx_dv) begin
            frames_left <= rx_byte;
            if (rx_byte == 8'h00) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (addr_oor) begin
              state <= ST_NAK;
            end else begin
              playing <= 1'b1;
              state   <= ST_FETCH;
            end
          end
        end

        ST_GET_DATA: begin
          if (commit) begin
            // Memory write happens this cycle via mem_we; bytes arriving now are dropped.
            commit <= 1'b0;
            ch     <= '0;
`ifdef POSE_ACK_EN
            tx_const    <= addr_oor ? 8'hEE : 8'h55;
            tx_from_mem <= 1'b0;
            tx_dv       <= 1'b1;
            ack_phase   <= 1'b1;
            state       <= ST_SEND;
`else
            busy  <= 1'b0;
            state <= ST_IDLE;
`endif
          end else if (rx_dv) begin
            shadow[ch*8 +: 8] <= rx_byte;
            if (ch == LAST_CH) begin
              commit     <= 1'b1;
              save_pulse <= !addr_oor;
              err_pulse  <= addr_oor;
            end else begin
              ch <= ch + 1'b1;
            end
          end
        end

        ST_FETCH: begin
          tx_from_mem <= 1'b1;
          tx_dv       <= 1'b1;
          state       <= ST_SEND;
        end

        ST_SEND: state <= ST_WAIT_ACT;

        ST_WAIT_ACT: begin
          if (tx_active)
            state <= ST_WAIT_DONE;
        end

        ST_WAIT_DONE: begin
          if (!tx_active) begin
            if (ack_phase) begin
              ack_phase <= 1'b0;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else if (ch != LAST_CH) begin
              ch    <= ch + 1'b1;
              state <= ST_FETCH;
            end else begin
              ch <= '0;
              if (frames_left != 8'd1) begin
                frames_left <= frames_left - 8'd1;
                gap_cnt     <= '0;
                state       <= ST_GAP;
              end else begin
                playing <= 1'b0;
`ifdef POSE_ACK_EN
                if (cmd == CMD_PLAY) begin
                  tx_const    <= 8'hAA;
                  tx_from_mem <= 1'b0;
                  tx_dv       <= 1'b1;
                  ack_phase   <= 1'b1;
                  state       <= ST_SEND;
                end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end
`else
                busy  <= 1'b0;
                state <= ST_IDLE;
`endif
              end
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == LAST_GAP) begin
            gap_cnt   <= '0;
            pose_addr <= (pose_addr == LAST_ADDR) ? 8'h00 : pose_addr + 8'd1;
            state     <= ST_FETCH;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        ST_NAK: begin
          tx_const    <= 8'hEE;
          tx_from_mem <= 1'b0;
          tx_dv       <= 1'b1;
          err_pulse   <= 1'b1;
          ack_phase   <= 1'b1;
          state       <= ST_SEND;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/servo_pose_store.md
# servo_pose_store

Parametrised pose memory and sequencer for the robotic arm: stores `NUM_CH` servo bytes per pose in `DEPTH` slots. Byte-stream commands write poses, read them back, or play a run of consecutive poses. It sits between the UART byte interface (rx/tx handshake signals, UART not instantiated here) and the status LEDs. Playback frames are separated by a programmable inter-frame gap.

## Interface

- `NUM_CH`, default 4: servo bytes per pose, 1..16.
- `DEPTH`, default 256: pose slots, 2..256. The address is one byte.
- `GAP_CYCLES`, default 2_500_000: idle cycles between played frames (100 ms at 25 MHz). Minimum 1.
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `rx_dv`, in, 1: one-cycle strobe, `rx_byte` valid.
- `rx_byte`, in, 8: received byte.
- `btn_play`, in, 1: debounced one-cycle pulse; plays pose 0 once.
- `tx_active`, in, 1: UART transmitter busy.
- `tx_dv`, out, 1: one-cycle strobe requesting transmission of `tx_byte`.
- `tx_byte`, out, 8: byte to send; held stable from `tx_dv` until the next `tx_dv`.
- `save_pulse`, out, 1: one-cycle pulse on each committed write.
- `busy`, out, 1: high in any state other than IDLE.
- `playing`, out, 1: high during read or play output, gaps included.
- `err_pulse`, out, 1: one-cycle pulse on an out-of-range address.

## Operation

**Commands** (accepted only in IDLE; unknown bytes are ignored):
- `0xA0 addr d0..d(NUM_CH-1)`: save pose.
- `0xB0 addr`: send one pose.
- `0xC0 addr count`: play `count` poses (1..255) from `addr`. A `count` of 0 aborts silently to IDLE.

**States:** IDLE, GET_ADDR, GET_DATA, GET_COUNT, FETCH, SEND, WAIT_ACT, WAIT_DONE, GAP, NAK.

- **GET_DATA**
  - Collects `NUM_CH` bytes into a shadow register; the channel counter runs 0..NUM_CH-1.
  - After the last byte, the whole pose is written in one cycle and `save_pulse` fires.
  - `addr >= DEPTH`: data is still consumed, the write is suppressed, `err_pulse` fires, no `save_pulse`.
- **FETCH**: synchronous memory read, 1-cycle latency, per channel byte.
- **SEND**: asserts `tx_dv` for one cycle with the fetched byte.
- **WAIT_ACT**: waits for `tx_active` = 1.
- **WAIT_DONE**: waits for `tx_active` = 0.
- **Next step after WAIT_DONE**:
  - Next channel → FETCH.
  - Pose complete with frames remaining → GAP.
  - Otherwise → IDLE.
- **GAP**
  - Counts `GAP_CYCLES`, then increments the pose address and returns to FETCH.
  - Wrap rule: the address wraps to 0 when it reaches DEPTH-1 and is incremented.
- **Read/play out of range**: start address `>= DEPTH` → NAK state, which sends `0xEE` once, pulses `err_pulse`, then returns to IDLE.
- **`btn_play`** in IDLE is equivalent to `0xC0 0x00 0x01`.
- **Simultaneous `rx_dv` and `btn_play` in IDLE**: the command byte wins and the button pulse is dropped.
- **`rx_dv` outside the receive states** (SEND/WAIT/GAP/FETCH/NAK): the byte is dropped; there is no queueing.
- **Reset mid-operation**
  - Returns to IDLE and clears all counters and outputs.
  - Memory contents are not reset; the memory is BRAM-inferable.

## Timing

- **Reset values:** `tx_dv`, `save_pulse`, `err_pulse`, `busy`, `playing` = 0; `tx_byte` = 0x00.
- **Write:** the memory write and `save_pulse` occur 1 cycle after the final data `rx_dv`.
- **First read byte:** `tx_dv` asserts 2 cycles after the address `rx_dv` (read) or the count `rx_dv` (play): FETCH then SEND.
- **Between bytes of a pose:** `tx_dv` asserts 2 cycles after `tx_active` falls.
- **Between frames:** the next frame's first `tx_dv` asserts `GAP_CYCLES + 2` cycles after `tx_active` falls.
- **`tx_active` handshake:** it must rise within 2 cycles of `tx_dv`. The block waits indefinitely in WAIT_ACT; no timeout.
- **Widths**
  - Channel counter: `$clog2(NUM_CH+1)` bits.
  - Gap counter: `$clog2(GAP_CYCLES+1)` bits.
  - Frame counter: 8 bits.

## Configuration

- **`POSE_ACK_EN` defined:**
  - Each successful save transmits `0x55` via SEND/WAIT before returning to IDLE; `busy` stays high until it completes.
  - An out-of-range save transmits `0xEE` instead of `0x55`.
  - Each completed play transmits `0xAA` after the last frame.
- **`POSE_ACK_EN` undefined:** saves and plays complete silently (the NAK for read/play still exists). Save latency back to IDLE is 1 cycle after `save_pulse`.

## Test plan

- **Save and read back:** `A0 05 10 20 30 40`, then `B0 05` → `save_pulse` once; TX sequence 10 20 30 40; `playing` high throughout the send.
- **Play with wrap:** DEPTH=8, GAP_CYCLES=50; save poses at 6, 7, 0, then `C0 06 03` → frames 6, 7, 0 in order; ≥50 idle cycles between frames.
- **Out of range:** DEPTH=8; `A0 09 …` → no write, one `err_pulse`. `B0 09` → TX `0xEE` only.
- **Button arbitration:** `btn_play` and `rx_dv`=`B0` in the same cycle → command path taken, pose 0 not sent twice. A lone `btn_play` → pose 0 sent once.
- **Busy drop and reset:** `rx_dv` bytes during a play are ignored. `reset_n` low mid-frame → `tx_dv`=0 and `busy`=0 immediately; memory is retained and readable after reset.
- **Acks:** with `POSE_ACK_EN` → the save emits `0x55` and play `C0 00 01` ends with `0xAA`. Without it → neither byte appears.
